uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//   Configurable UART receiver: 5-9 data bits, LSB first, optional even/odd parity, 1 or 2 stop bits.
//   Reports parity error, framing error and break per received word.
//   Rejects start-bit glitches and re-arms only after the line returns to idle.
//   Sits between the board RX pin and the command decoder; same place as the fixed 8N1 receiver.
// PARAMETERS
//   CLKS_PER_BIT  3603  clocks per bit = f(i_Clock)/baud; must be >= 4
//   DATA_BITS     8     data bits per word, legal range 5..9
//   PARITY_MODE   0     0 = none, 1 = even, 2 = odd
//   STOP_BITS     1     1 or 2
// PORTS
//   i_Clock       in   1          system clock; all logic on posedge
//   i_Reset_n     in   1          asynchronous active-low reset
//   i_Rx_Serial   in   1          asynchronous serial line, idle high
//   o_Rx_DV       out  1          one-cycle pulse: word and status valid
//   o_Rx_Data     out  DATA_BITS  received word, bit 0 = first bit on the line
//   o_Parity_Err  out  1          parity mismatch on the last word; 0 when PARITY_MODE = 0
//   o_Frame_Err   out  1          a stop bit sampled low on the last word
//   o_Break       out  1          last word: all data, parity and stop samples low
//   o_Busy        out  1          high from start-bit detection until return to IDLE
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - Both synchroniser flops = 1; FSM = IDLE; counters = 0.
//     - All outputs = 0. Reset mid-frame discards the partial word; no DV is produced.
//   Sync and counters:
//     - 2-flop synchroniser; the FSM sees only the second flop (rx_s).
//     - Clock counter width = $clog2(CLKS_PER_BIT). H = (CLKS_PER_BIT-1)/2, integer divide.
//   States:
//     - IDLE: cnt = 0, idx = 0, o_Busy = 0. rx_s = 0 -> START.
//     - START: cnt increments to H, then rx_s is sampled.
//         rx_s = 1 -> IDLE (glitch; no DV, no status change).
//         rx_s = 0 -> cnt = 0, -> DATA.
//     - DATA: at cnt = CLKS_PER_BIT-1, sample into shift[idx] and clear cnt.
//         Continue until idx = DATA_BITS-1, then -> PARITY if PARITY_MODE != 0, else -> STOP.
//     - PARITY: sample one bit at the same spacing.
//         perr = (^data ^ pbit) != (PARITY_MODE == 2).
//     - STOP: sample STOP_BITS bits at the same spacing.
//         ferr = any stop sample == 0. After the last stop sample -> DONE.
//     - DONE (1 cycle):
//         o_Rx_DV = 1; o_Rx_Data, o_Parity_Err, o_Frame_Err, o_Break load.
//         ferr = 1 -> WAIT_HI; else -> IDLE.
//     - WAIT_HI: remain until rx_s = 1, then -> IDLE.
//         A held-low line therefore yields exactly one word, not a stream.
//   Timing:
//     - All sample points are exactly CLKS_PER_BIT clocks apart.
//     - The first data sample is CLKS_PER_BIT clocks after the start-bit mid check.
//     - o_Rx_DV is high the cycle after the last stop sample, which is about half a bit before the stop-bit end.
//       This allows back-to-back frames with no idle gap.
//   Outputs:
//     - o_Rx_DV is high for exactly 1 cycle per accepted word.
//     - Data and status registers hold their values until the next DV. They are never cleared by a glitch.
//     - Illegal PARITY_MODE / STOP_BITS / DATA_BITS: compile-time error via a generate-time check.
// TESTING  (CLKS_PER_BIT = 16 unless noted)
//   1. 8N1, send 0xA5 with 1-bit idle gap
//      -> one DV; o_Rx_Data = 8'hA5; all error flags 0.
//   2. 7E1, send 0x41 with parity bit 0
//      -> DV, data 7'h41, perr 0.
//      Resend with parity bit 1 -> DV, data 7'h41, o_Parity_Err = 1.
//   3. 8O2, 0x3C with good parity, first stop 1, second stop 0
//      -> DV, o_Frame_Err = 1, o_Busy stays high while the line stays low.
//      Line high -> o_Busy = 0.
//   4. Low pulse of 5 clocks on the idle line -> no DV, o_Busy returns to 0, previous outputs unchanged.
//   5. Line held low for 30 bit times, 8N1
//      -> exactly one DV with data 0x00, o_Break = 1, o_Frame_Err = 1.
//   6. Assert reset in the middle of bit 4 of 0xFF, release, then send 0x12
//      -> no DV for 0xFF; one DV with 0x12.
//      Repeat 0x55 and 0xAA back-to-back, DATA_BITS = 9, CLKS_PER_BIT = 5 -> two DVs, correct data.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5-9 data bits, LSB first,
// optional even/odd parity, 1 or 2 stop bits). Reports parity error,
// framing error and break per word, rejects start-bit glitches, and after
// a framing error waits for the line to go idle before re-arming.
`timescale 1ns/1ps
module uart_rx_cfg #(
   parameter int CLKS_PER_BIT = 3603,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset_n,
   input  logic                 i_Rx_Serial,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Data,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Break,
   output logic                 o_Busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START   = 3'd1;
   localparam logic [2:0] ST_DATA    = 3'd2;
   localparam logic [2:0] ST_PARITY  = 3'd3;
   localparam logic [2:0] ST_STOP    = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;
   localparam logic [2:0] ST_WAIT_HI = 3'd6;

   generate
      if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
          PARITY_MODE < 0 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
         $error("uart_rx_cfg: illegal CLKS_PER_BIT / DATA_BITS / PARITY_MODE / STOP_BITS");
      end
   endgenerate

   // XOR-reduction of the data word; 1 when it holds an odd number of ones.
   function automatic logic odd_ones(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

   logic                 rx_meta_r;
   logic                 rx_s;
   logic [2:0]           state_r,  state_nx_s;
   logic [CW-1:0]        cnt_r,    cnt_nx_s;
   logic [IW-1:0]        idx_r,    idx_nx_s;
   logic                 stop_r,   stop_nx_s;
   logic [DATA_BITS-1:0] shift_r,  shift_nx_s;
   logic                 pbit_r,   pbit_nx_s;
   logic                 ferr_r,   ferr_nx_s;
   logic                 high_r,   high_nx_s;   // any data/parity/stop sample was 1
   logic                 bit_tick_s;
   logic                 perr_s;

   assign bit_tick_s = (cnt_r == CNT_LAST);
   assign perr_s = (PARITY_MODE != 0) ?
                   ((odd_ones(shift_nx_s) ^ pbit_nx_s) != (PARITY_MODE == 2)) : 1'b0;

   // Two-flop synchroniser for the asynchronous serial line (idles high).
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         rx_meta_r <= 1'b1;
         rx_s      <= 1'b1;
      end else begin
         rx_meta_r <= i_Rx_Serial;
         rx_s      <= rx_meta_r;
      end
   end

   // Next-state and sample-accumulation logic of the frame FSM.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      idx_nx_s   = idx_r;
      stop_nx_s  = stop_r;
      shift_nx_s = shift_r;
      pbit_nx_s  = pbit_r;
      ferr_nx_s  = ferr_r;
      high_nx_s  = high_r;
      case (state_r)
         ST_IDLE: begin
            cnt_nx_s  = '0;
            idx_nx_s  = '0;
            stop_nx_s = 1'b0;
            if (!rx_s) begin
               state_nx_s = ST_START;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (cnt_r == CNT_HALF) begin
               cnt_nx_s = '0;
               if (rx_s) begin
                  state_nx_s = ST_IDLE;          // glitch: not a real start bit
               end else begin
                  state_nx_s = ST_DATA;
                  shift_nx_s = '0;
                  pbit_nx_s  = 1'b0;
                  ferr_nx_s  = 1'b0;
                  high_nx_s  = 1'b0;
               end
            end else begin
               cnt_nx_s = cnt_r + CW'(1);
            end
         end
         ST_DATA: begin
            if (bit_tick_s) begin
               cnt_nx_s           = '0;
               shift_nx_s[idx_r]  = rx_s;
               high_nx_s          = high_r | rx_s;
               if (idx_r == IDX_LAST) begin
                  idx_nx_s   = '0;
                  state_nx_s = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  idx_nx_s = idx_r + IW'(1);
               end
            end else begin
               cnt_nx_s = cnt_r + CW'(1);
            end
         end
         ST_PARITY: begin
            if (bit_tick_s) begin
               cnt_nx_s   = '0;
               pbit_nx_s  = rx_s;
               high_nx_s  = high_r | rx_s;
               state_nx_s = ST_STOP;
            end else begin
               cnt_nx_s = cnt_r + CW'(1);
            end
         end
         ST_STOP: begin
            if (bit_tick_s) begin
               cnt_nx_s  = '0;
               high_nx_s = high_r | rx_s;
               ferr_nx_s = ferr_r | ~rx_s;
               if (stop_r == STOP_LAST) begin
                  stop_nx_s  = 1'b0;
                  state_nx_s = ST_DONE;
               end else begin
                  stop_nx_s = 1'b1;
               end
            end else begin
               cnt_nx_s = cnt_r + CW'(1);
            end
         end
         ST_DONE: begin
            if (ferr_r) begin
               state_nx_s = ST_WAIT_HI;          // line may be held low: wait for idle
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_WAIT_HI: begin
            if (rx_s) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_WAIT_HI;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = '0;
            idx_nx_s   = '0;
            stop_nx_s  = 1'b0;
         end
      endcase
   end

   // FSM state, bit-timing counter and sample registers.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         idx_r   <= '0;
         stop_r  <= 1'b0;
         shift_r <= '0;
         pbit_r  <= 1'b0;
         ferr_r  <= 1'b0;
         high_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
         idx_r   <= idx_nx_s;
         stop_r  <= stop_nx_s;
         shift_r <= shift_nx_s;
         pbit_r  <= pbit_nx_s;
         ferr_r  <= ferr_nx_s;
         high_r  <= high_nx_s;
      end
   end

   // Registered outputs: word and status load together with the DV pulse.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         o_Rx_DV      <= 1'b0;
         o_Rx_Data    <= '0;
         o_Parity_Err <= 1'b0;
         o_Frame_Err  <= 1'b0;
         o_Break      <= 1'b0;
         o_Busy       <= 1'b0;
      end else begin
         o_Busy <= (state_nx_s != ST_IDLE);
         if (state_nx_s == ST_DONE) begin
            o_Rx_DV      <= 1'b1;
            o_Rx_Data    <= shift_nx_s;
            o_Parity_Err <= perr_s;
            o_Frame_Err  <= ferr_nx_s;
            o_Break      <= ~high_nx_s;
         end else begin
            o_Rx_DV <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: four instances (8N1, 7E1, 8O2 at 16 clocks/bit,
// 9N1 at 5 clocks/bit) driven with directed and random frames. Expected
// words come from a frame-level model computed from the bits the bench sends.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

   typedef struct {
      int         id;
      logic [8:0] data;
      logic       perr;
      logic       ferr;
      logic       brk;
      int         lo;
      int         hi;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] rx;
   int         cyc;
   int         tests;
   int         fails;
   exp_t       expq[$];

   logic [7:0] d0;
   logic [6:0] d1;
   logic [7:0] d2;
   logic [8:0] d3;
   logic [3:0] dv_w, perr_w, ferr_w, brk_w, busy_w;
   logic [3:0] prev_dv;
   logic [8:0] dat_w [4];

   assign dat_w[0] = {1'b0, d0};
   assign dat_w[1] = {2'b00, d1};
   assign dat_w[2] = {1'b0, d2};
   assign dat_w[3] = d3;

   uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
      .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv_w[0]), .o_Rx_Data(d0),
      .o_Parity_Err(perr_w[0]), .o_Frame_Err(ferr_w[0]), .o_Break(brk_w[0]), .o_Busy(busy_w[0]));
   uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u_dut1 (
      .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv_w[1]), .o_Rx_Data(d1),
      .o_Parity_Err(perr_w[1]), .o_Frame_Err(ferr_w[1]), .o_Break(brk_w[1]), .o_Busy(busy_w[1]));
   uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2)) u_dut2 (
      .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv_w[2]), .o_Rx_Data(d2),
      .o_Parity_Err(perr_w[2]), .o_Frame_Err(ferr_w[2]), .o_Break(brk_w[2]), .o_Busy(busy_w[2]));
   uart_rx_cfg #(.CLKS_PER_BIT(5), .DATA_BITS(9), .PARITY_MODE(0), .STOP_BITS(1)) u_dut3 (
      .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(rx[3]), .o_Rx_DV(dv_w[3]), .o_Rx_Data(d3),
      .o_Parity_Err(perr_w[3]), .o_Frame_Err(ferr_w[3]), .o_Break(brk_w[3]), .o_Busy(busy_w[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int cpb(input int id);
      return (id == 3) ? 5 : 16;
   endfunction
   function automatic int db(input int id);
      case (id)
         1: return 7;
         3: return 9;
         default: return 8;
      endcase
   endfunction
   function automatic int pm(input int id);
      case (id)
         1: return 1;
         2: return 2;
         default: return 0;
      endcase
   endfunction
   function automatic int sb(input int id);
      return (id == 2) ? 2 : 1;
   endfunction

   // Frame-level expectation from the bits placed on the line.
   function automatic exp_t model(input int id, input logic [8:0] data, input logic pbit,
                                  input logic [1:0] stops, input int n0);
      exp_t e;
      logic [8:0] d;
      int ones, last, c;
      d = data & ((9'd1 << db(id)) - 9'd1);
      ones = $countones(d);
      e.id = id;
      e.data = d;
      case (pm(id))
         1: e.perr = ((ones + int'(pbit)) % 2) != 0;
         2: e.perr = ((ones + int'(pbit)) % 2) == 0;
         default: e.perr = 1'b0;
      endcase
      e.ferr = !stops[0] || (sb(id) == 2 && !stops[1]);
      e.brk  = (d == 9'd0) && (pm(id) == 0 || !pbit) && !stops[0] && (sb(id) == 1 || !stops[1]);
      c = cpb(id);
      last = db(id) + ((pm(id) != 0) ? 1 : 0) + sb(id);
      e.lo = n0 + last * c + c / 2;
      e.hi = n0 + (last + 1) * c + 4;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic hold(input int id, input logic lvl, input int nclk);
      rx[id] = lvl;
      wait_clk(nclk);
   endtask

   task automatic send_frame(input int id, input logic [8:0] data, input logic pbit,
                             input logic [1:0] stops, input int gap);
      int c;
      c = cpb(id);
      expq.push_back(model(id, data, pbit, stops, cyc));
      hold(id, 1'b0, c);
      for (int k = 0; k < db(id); k++) hold(id, data[k], c);
      if (pm(id) != 0) hold(id, pbit, c);
      for (int k = 0; k < sb(id); k++) hold(id, stops[k], c);
      if (gap > 0) hold(id, 1'b1, gap * c);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (expq.size() != 0 && n < 3000);
      #1;
      chk(name, 32'(expq.size()), 32'd0);
      expq.delete();
   endtask

   task automatic chk_idle_outputs(input string name, input int id);
      chk({name, "_dv"},   32'(dv_w[id]),   32'd0);
      chk({name, "_data"}, 32'(dat_w[id]),  32'd0);
      chk({name, "_perr"}, 32'(perr_w[id]), 32'd0);
      chk({name, "_ferr"}, 32'(ferr_w[id]), 32'd0);
      chk({name, "_brk"},  32'(brk_w[id]),  32'd0);
      chk({name, "_busy"}, 32'(busy_w[id]), 32'd0);
   endtask

   // Compare process: every DV pulse is matched against the next expected word.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            if (dv_w[i]) begin
               exp_t e;
               chk("dv_one_cycle", 32'(prev_dv[i]), 32'd0);
               if (expq.size() == 0 || expq[0].id != i) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_dv: dut %0d got data 0x%0h, expected no word", i, dat_w[i]);
               end else begin
                  e = expq.pop_front();
                  chk("word_data", 32'(dat_w[i]), 32'(e.data));
                  chk("word_perr", 32'(perr_w[i]), 32'(e.perr));
                  chk("word_ferr", 32'(ferr_w[i]), 32'(e.ferr));
                  chk("word_brk",  32'(brk_w[i]),  32'(e.brk));
                  chk("dv_time_in_window", 32'(cyc >= e.lo && cyc <= e.hi), 32'd1);
               end
            end
         end
      end
      prev_dv <= dv_w;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t m;
      logic [8:0] d;
      logic [1:0] st;
      logic       pb;
      int         gap;
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      rx    = 4'hF;
      wait_clk(5);
      rst_n = 1'b1;
      wait_clk(3);

      // Reset state
      chk_idle_outputs("reset0", 0);
      chk_idle_outputs("reset3", 3);

      // Pin the model with hand-computed cases
      m = model(1, 9'h041, 1'b0, 2'b11, 0);
      chk("model_7e1_good", 32'(m.perr), 32'd0);
      m = model(1, 9'h041, 1'b1, 2'b11, 0);
      chk("model_7e1_bad", 32'(m.perr), 32'd1);
      m = model(2, 9'h03C, 1'b1, 2'b01, 0);
      chk("model_8o2_perr", 32'(m.perr), 32'd0);
      chk("model_8o2_ferr", 32'(m.ferr), 32'd1);
      m = model(0, 9'h000, 1'b0, 2'b00, 0);
      chk("model_break", 32'(m.brk), 32'd1);

      // 1. 8N1 0xA5
      send_frame(0, 9'h0A5, 1'b0, 2'b11, 1);
      drain("t1_drain");
      chk("t1_data", 32'(dat_w[0]), 32'hA5);
      chk("t1_flags", 32'({perr_w[0], ferr_w[0], brk_w[0]}), 32'd0);

      // 4. 5-clock glitch: no DV, not busy, outputs kept
      hold(0, 1'b0, 5);
      hold(0, 1'b1, 40);
      chk("t4_busy", 32'(busy_w[0]), 32'd0);
      chk("t4_data_held", 32'(dat_w[0]), 32'hA5);
      chk("t4_flags_held", 32'({perr_w[0], ferr_w[0], brk_w[0]}), 32'd0);

      // 2. 7E1 0x41 with good then bad parity
      send_frame(1, 9'h041, 1'b0, 2'b11, 1);
      drain("t2a_drain");
      chk("t2a_data", 32'(dat_w[1]), 32'h41);
      chk("t2a_perr", 32'(perr_w[1]), 32'd0);
      send_frame(1, 9'h041, 1'b1, 2'b11, 1);
      drain("t2b_drain");
      chk("t2b_data", 32'(dat_w[1]), 32'h41);
      chk("t2b_perr", 32'(perr_w[1]), 32'd1);

      // 3. 8O2 0x3C, second stop low, line held low afterwards
      send_frame(2, 9'h03C, 1'b1, 2'b01, 0);
      drain("t3_drain");
      wait_clk(48);
      chk("t3_busy_low_line", 32'(busy_w[2]), 32'd1);
      chk("t3_ferr", 32'(ferr_w[2]), 32'd1);
      chk("t3_perr", 32'(perr_w[2]), 32'd0);
      chk("t3_data", 32'(dat_w[2]), 32'h3C);
      hold(2, 1'b1, 10);
      chk("t3_busy_released", 32'(busy_w[2]), 32'd0);

      // 5. Line held low for 30 bit times: exactly one break word
      m.id = 0; m.data = 9'd0; m.perr = 1'b0; m.ferr = 1'b1; m.brk = 1'b1;
      m.lo = cyc; m.hi = cyc + 30 * 16;
      expq.push_back(m);
      hold(0, 1'b0, 30 * 16);
      hold(0, 1'b1, 16);
      drain("t5_drain");
      chk("t5_data", 32'(dat_w[0]), 32'h00);
      chk("t5_break", 32'(brk_w[0]), 32'd1);
      chk("t5_ferr", 32'(ferr_w[0]), 32'd1);
      chk("t5_busy", 32'(busy_w[0]), 32'd0);

      // 6. Reset in the middle of bit 4 of 0xFF, then 0x12
      hold(0, 1'b0, 16);
      for (int k = 0; k < 4; k++) hold(0, 1'b1, 16);
      hold(0, 1'b1, 8);
      rst_n = 1'b0;
      rx[0] = 1'b1;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(2);
      chk_idle_outputs("t6_after_reset", 0);
      send_frame(0, 9'h012, 1'b0, 2'b11, 1);
      drain("t6_drain");
      chk("t6_data", 32'(dat_w[0]), 32'h12);

      // 6b. 9N1 at 5 clocks/bit, back-to-back 0x55 then 0xAA
      send_frame(3, 9'h055, 1'b0, 2'b11, 0);
      send_frame(3, 9'h0AA, 1'b0, 2'b11, 1);
      drain("t6b_drain");
      chk("t6b_last_data", 32'(dat_w[3]), 32'h0AA);

      // Random frames on every configuration
      for (int id = 0; id < 4; id++) begin
         for (int n = 0; n < 25; n++) begin
            d = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 9) == 0) d = 9'd0;
            pb = ^(d & ((9'd1 << db(id)) - 9'd1));
            if (pm(id) == 2) pb = ~pb;
            if ($urandom_range(0, 3) == 0) pb = ~pb;
            st[0] = ($urandom_range(0, 5) != 0);
            st[1] = ($urandom_range(0, 5) != 0);
            if (d == 9'd0 && $urandom_range(0, 1) == 0) begin
               st = 2'b00;
               pb = 1'b0;
            end
            gap = $urandom_range(0, 2);
            if (sb(id) == 1) st[1] = 1'b1;
            if (st != 2'b11 && gap == 0) gap = 1;
            send_frame(id, d, pb, st, gap);
         end
         hold(id, 1'b1, 2 * cpb(id));
         drain("rand_drain");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
